// File: rtl/output_uart_tx_if.sv
// CPU-side bundle for output_uart_tx: output-register write strobe/data in,
// transmitter status out.
interface output_uart_tx_if #(
   parameter int unsigned DataWidth = 16
);
   logic                 OutWr;
   logic [DataWidth-1:0] OutData;
   logic                 Busy;
   logic                 Full;
   logic                 Overflow;

   modport master (
      output OutWr,
      output OutData,
      input  Busy,
      input  Full,
      input  Overflow
   );

   modport slave (
      input  OutWr,
      input  OutData,
      output Busy,
      output Full,
      output Overflow
   );
endinterface

// File: rtl/output_uart_tx.sv
// Buffers CPU output-register writes in a word FIFO and sends each word over an
// 8N1 UART line, most-significant byte first, LSB first within a byte.
module output_uart_tx #(
   parameter int unsigned DataWidth = 16,
   parameter int unsigned FifoDepth = 4,
   parameter int unsigned ClkPerBit = 16
) (
   input  logic            Clk,
   input  logic            Reset,
   output_uart_tx_if.slave cpu,
   output logic            Tx
);

   localparam int unsigned BytesPerWord = DataWidth / 8;
   localparam int unsigned PtrW         = $clog2(FifoDepth);
   localparam int unsigned CntW         = PtrW + 1;
   localparam int unsigned BaudW        = (ClkPerBit > 1) ? $clog2(ClkPerBit) : 1;
   localparam int unsigned ByteW        = (BytesPerWord > 1) ? $clog2(BytesPerWord) : 1;

   typedef enum logic [1:0] {
      S_Idle,
      S_Start,
      S_Data,
      S_Stop
   } state_t;

   state_t               state;
   logic [DataWidth-1:0] mem [FifoDepth];
   logic [PtrW-1:0]      wr_ptr;
   logic [PtrW-1:0]      rd_ptr;
   logic [CntW-1:0]      count;
   logic                 overflow;

   logic [DataWidth-1:0] shift_word;
   logic [BaudW-1:0]     baud_cnt;
   logic [2:0]           bit_idx;
   logic [ByteW-1:0]     byte_idx;
   logic                 tx_reg;

   logic                 fifo_empty;
   logic                 fifo_full;
   logic                 bit_done;
   logic                 last_byte;
   logic                 pop;
   logic                 push;
   logic [7:0]           cur_byte;
   logic [2:0]           next_bit;

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == CntW'(FifoDepth));
   assign bit_done   = (baud_cnt == BaudW'(ClkPerBit - 1));
   assign last_byte  = (byte_idx == ByteW'(BytesPerWord - 1));
   assign cur_byte   = shift_word[DataWidth-1 -: 8];
   assign next_bit   = bit_idx + 3'd1;

   // A pop happens only where the FSM loads a new word: from idle, or at the
   // end of the final stop bit so consecutive words run without a gap.
   always_comb begin
      pop = 1'b0;
      if (!fifo_empty) begin
         if (state == S_Idle) begin
            pop = 1'b1;
         end else if (state == S_Stop && bit_done && last_byte) begin
            pop = 1'b1;
         end
      end
   end

   assign push = cpu.OutWr && (!fifo_full || pop);

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (cpu.OutWr && !push) begin
            overflow <= 1'b1;
         end
      end
   end

   // Storage carries no reset; occupancy is tracked by the pointers and count.
   always_ff @(posedge Clk) begin
      if (push) begin
         mem[wr_ptr] <= cpu.OutData;
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state      <= S_Idle;
         tx_reg     <= 1'b1;
         shift_word <= '0;
         baud_cnt   <= '0;
         bit_idx    <= '0;
         byte_idx   <= '0;
      end else begin
         case (state)
            S_Idle: begin
               baud_cnt <= '0;
               tx_reg   <= 1'b1;
               if (pop) begin
                  shift_word <= mem[rd_ptr];
                  byte_idx   <= '0;
                  tx_reg     <= 1'b0;
                  state      <= S_Start;
               end
            end
            S_Start: begin
               if (bit_done) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  tx_reg   <= cur_byte[0];
                  state    <= S_Data;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            S_Data: begin
               if (bit_done) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     tx_reg <= 1'b1;
                     state  <= S_Stop;
                  end else begin
                     bit_idx <= next_bit;
                     tx_reg  <= cur_byte[next_bit];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            S_Stop: begin
               if (bit_done) begin
                  baud_cnt <= '0;
                  if (!last_byte) begin
                     // Next byte of the same word sits in the top byte after the shift.
                     byte_idx   <= byte_idx + 1'b1;
                     shift_word <= shift_word << 8;
                     tx_reg     <= 1'b0;
                     state      <= S_Start;
                  end else if (pop) begin
                     shift_word <= mem[rd_ptr];
                     byte_idx   <= '0;
                     tx_reg     <= 1'b0;
                     state      <= S_Start;
                  end else begin
                     tx_reg <= 1'b1;
                     state  <= S_Idle;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: begin
               tx_reg <= 1'b1;
               state  <= S_Idle;
            end
         endcase
      end
   end

   assign Tx           = tx_reg;
   assign cpu.Busy     = (state != S_Idle) || !fifo_empty;
   assign cpu.Full     = fifo_full;
   assign cpu.Overflow = overflow;

endmodule

// File: tb/tb_output_uart_tx.sv
// Bench for output_uart_tx: a behavioural UART receiver decodes Tx into a byte
// queue that each scenario task checks against bytes it queued at stimulus time.
module tb_output_uart_tx;

   localparam int unsigned CPB = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic tx;
   int unsigned cyc = 0;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0]  exp_q[$];
   logic [7:0]  rx_q[$];
   bit          rx_ok_q[$];
   int unsigned rx_cyc_q[$];

   output_uart_tx_if #(.DataWidth(16)) bus ();

   output_uart_tx #(
      .DataWidth(16),
      .FifoDepth(4),
      .ClkPerBit(CPB)
   ) dut (
      .Clk  (clk),
      .Reset(rst_n),
      .cpu  (bus),
      .Tx   (tx)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Receiver: start seen at the first negedge with Tx low, then each bit is
   // sampled 2.5 cycles into its period.
   bit          rx_busy = 1'b0;
   int unsigned rx_cnt = 0;
   int unsigned rx_start_cyc = 0;
   logic        rx_start_bit;
   logic [7:0]  rx_shift;

   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_busy = 1'b0;
         rx_cnt  = 0;
      end else if (!rx_busy) begin
         if (tx === 1'b0) begin
            rx_busy      = 1'b1;
            rx_cnt       = 0;
            rx_start_cyc = cyc;
         end
      end else begin
         rx_cnt++;
         if (rx_cnt % CPB == 2) begin
            if (rx_cnt / CPB == 0) begin
               rx_start_bit = tx;
            end else if (rx_cnt / CPB <= 8) begin
               rx_shift[rx_cnt / CPB - 1] = tx;
            end else begin
               rx_q.push_back(rx_shift);
               rx_ok_q.push_back(rx_start_bit === 1'b0 && tx === 1'b1);
               rx_cyc_q.push_back(rx_start_cyc);
               rx_busy = 1'b0;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   task automatic wait_rx(input int n, input int budget, output bit ok);
      int c = 0;
      while (rx_q.size() < n && c < budget) begin
         @(negedge clk);
         c++;
      end
      ok = (rx_q.size() >= n);
   endtask

   task automatic wait_idle(input string tag);
      int c = 0;
      while (bus.Busy !== 1'b0 && c < 2000) begin
         @(negedge clk);
         c++;
      end
      vectors++;
      if (bus.Busy !== 1'b0) begin
         $display("FAIL %s_idle: Busy=%b expected 0 within 2000 cycles", tag, bus.Busy);
         miscompares++;
      end
      repeat (8) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         vectors++;
         if ({tx, bus.Busy, bus.Full, bus.Overflow} !== 4'b1000) begin
            $display("FAIL reset_idle cycle %0d: {Tx,Busy,Full,Overflow}=%b expected 1000",
                     i, {tx, bus.Busy, bus.Full, bus.Overflow});
            miscompares++;
         end
      end
   endtask

   task automatic test_single();
      int unsigned w;
      bit ok;
      logic [7:0] e, a;
      bit f;
      int unsigned c;
      bus.OutData = 16'hA55A;
      bus.OutWr   = 1'b1;
      @(posedge clk);
      #1;
      w = cyc;
      bus.OutWr = 1'b0;
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h5A);
      while (cyc != w + 80) @(negedge clk);
      vectors++;
      if (bus.Busy !== 1'b1 || tx !== 1'b1) begin
         $display("FAIL single_last_stop: Busy=%b Tx=%b expected 1 1", bus.Busy, tx);
         miscompares++;
      end
      @(negedge clk);
      vectors++;
      if (bus.Busy !== 1'b0) begin
         $display("FAIL single_done_at_80: Busy=%b expected 0", bus.Busy);
         miscompares++;
      end
      wait_rx(2, 50, ok);
      vectors++;
      if (!ok) begin
         $display("FAIL single_rx_count: got %0d bytes expected 2", rx_q.size());
         miscompares++;
      end
      for (int i = 0; rx_q.size() > 0 && exp_q.size() > 0; i++) begin
         e = exp_q.pop_front();
         a = rx_q.pop_front();
         f = rx_ok_q.pop_front();
         c = rx_cyc_q.pop_front();
         vectors++;
         if (a !== e || !f) begin
            $display("FAIL single_byte%0d: got %h framing_ok=%0d expected %h", i, a, f, e);
            miscompares++;
         end
         vectors++;
         if (c !== w + 1 + 40 * i) begin
            $display("FAIL single_start%0d: start cycle %0d expected %0d", i, c, w + 1 + 40 * i);
            miscompares++;
         end
      end
      wait_idle("single");
   endtask

   task automatic test_back_to_back();
      bit ok;
      logic [7:0] e, a;
      bit f;
      int unsigned c, prev;
      logic [15:0] d;
      for (int i = 1; i <= 5; i++) begin
         d = 16'(i);
         bus.OutData = d;
         bus.OutWr   = 1'b1;
         exp_q.push_back(d[15:8]);
         exp_q.push_back(d[7:0]);
         @(posedge clk);
         #1;
      end
      bus.OutWr = 1'b0;
      wait_rx(10, 600, ok);
      vectors++;
      if (!ok) begin
         $display("FAIL b2b_rx_count: got %0d bytes expected 10", rx_q.size());
         miscompares++;
      end
      prev = 0;
      for (int i = 0; rx_q.size() > 0 && exp_q.size() > 0; i++) begin
         e = exp_q.pop_front();
         a = rx_q.pop_front();
         f = rx_ok_q.pop_front();
         c = rx_cyc_q.pop_front();
         vectors++;
         if (a !== e || !f) begin
            $display("FAIL b2b_byte%0d: got %h framing_ok=%0d expected %h", i, a, f, e);
            miscompares++;
         end
         if (i > 0) begin
            vectors++;
            if (c - prev !== 40) begin
               $display("FAIL b2b_gap%0d: byte spacing %0d expected 40", i, c - prev);
               miscompares++;
            end
         end
         prev = c;
      end
      vectors++;
      if (bus.Overflow !== 1'b0) begin
         $display("FAIL b2b_overflow: Overflow=%b expected 0", bus.Overflow);
         miscompares++;
      end
      wait_idle("b2b");
   endtask

   task automatic test_overflow();
      bit ok;
      logic [7:0] e, a;
      bit f;
      logic [15:0] d;
      for (int i = 0; i < 6; i++) begin
         d = 16'h0B01 + 16'(i);
         bus.OutData = d;
         bus.OutWr   = 1'b1;
         if (i < 5) begin
            exp_q.push_back(d[15:8]);
            exp_q.push_back(d[7:0]);
         end
         @(posedge clk);
         #1;
         if (i == 3) begin
            vectors++;
            if (bus.Full !== 1'b0) begin
               $display("FAIL ovf_not_full_after4: Full=%b expected 0", bus.Full);
               miscompares++;
            end
         end
         if (i == 4) begin
            vectors++;
            if (bus.Full !== 1'b1 || bus.Overflow !== 1'b0) begin
               $display("FAIL ovf_full_after5: Full=%b Overflow=%b expected 1 0", bus.Full, bus.Overflow);
               miscompares++;
            end
         end
      end
      bus.OutWr = 1'b0;
      vectors++;
      if (bus.Overflow !== 1'b1 || bus.Full !== 1'b1) begin
         $display("FAIL ovf_dropped6: Overflow=%b Full=%b expected 1 1", bus.Overflow, bus.Full);
         miscompares++;
      end
      wait_rx(10, 600, ok);
      vectors++;
      if (!ok) begin
         $display("FAIL ovf_rx_count: got %0d bytes expected 10", rx_q.size());
         miscompares++;
      end
      for (int i = 0; rx_q.size() > 0 && exp_q.size() > 0; i++) begin
         e = exp_q.pop_front();
         a = rx_q.pop_front();
         f = rx_ok_q.pop_front();
         void'(rx_cyc_q.pop_front());
         vectors++;
         if (a !== e || !f) begin
            $display("FAIL ovf_byte%0d: got %h framing_ok=%0d expected %h", i, a, f, e);
            miscompares++;
         end
      end
      wait_idle("ovf");
      repeat (40) @(negedge clk);
      vectors++;
      if (rx_q.size() !== 0 || bus.Overflow !== 1'b1) begin
         $display("FAIL ovf_extra: extra bytes=%0d Overflow=%b expected 0 1", rx_q.size(), bus.Overflow);
         miscompares++;
      end
   endtask

   task automatic test_reset_mid();
      int unsigned w;
      bit ok;
      logic [7:0] e, a;
      bit f;
      bus.OutData = 16'hFFFF;
      bus.OutWr   = 1'b1;
      @(posedge clk);
      #1;
      w = cyc;
      bus.OutWr = 1'b0;
      while (cyc != w + 10) begin
         @(posedge clk);
         #1;
      end
      vectors++;
      if (tx !== 1'b1 || bus.Busy !== 1'b1) begin
         $display("FAIL rstmid_in_data: Tx=%b Busy=%b expected 1 1", tx, bus.Busy);
         miscompares++;
      end
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({tx, bus.Busy, bus.Full, bus.Overflow} !== 4'b1000) begin
         $display("FAIL rstmid_async: {Tx,Busy,Full,Overflow}=%b expected 1000",
                  {tx, bus.Busy, bus.Full, bus.Overflow});
         miscompares++;
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      vectors++;
      if (tx !== 1'b1 || bus.Busy !== 1'b0 || rx_q.size() !== 0) begin
         $display("FAIL rstmid_after: Tx=%b Busy=%b rx_bytes=%0d expected 1 0 0", tx, bus.Busy, rx_q.size());
         miscompares++;
      end
      bus.OutData = 16'h1234;
      bus.OutWr   = 1'b1;
      exp_q.push_back(8'h12);
      exp_q.push_back(8'h34);
      @(posedge clk);
      #1;
      bus.OutWr = 1'b0;
      wait_rx(2, 200, ok);
      vectors++;
      if (!ok) begin
         $display("FAIL rstmid_rx_count: got %0d bytes expected 2", rx_q.size());
         miscompares++;
      end
      for (int i = 0; rx_q.size() > 0 && exp_q.size() > 0; i++) begin
         e = exp_q.pop_front();
         a = rx_q.pop_front();
         f = rx_ok_q.pop_front();
         void'(rx_cyc_q.pop_front());
         vectors++;
         if (a !== e || !f) begin
            $display("FAIL rstmid_byte%0d: got %h framing_ok=%0d expected %h", i, a, f, e);
            miscompares++;
         end
      end
      wait_idle("rstmid");
   endtask

   task automatic test_full_pop();
      int unsigned n;
      bit ok;
      logic [7:0] e, a;
      bit f;
      logic [15:0] d;
      n = 0;
      for (int i = 0; i < 5; i++) begin
         d = 16'hA001 + 16'(i);
         bus.OutData = d;
         bus.OutWr   = 1'b1;
         exp_q.push_back(d[15:8]);
         exp_q.push_back(d[7:0]);
         @(posedge clk);
         #1;
         if (i == 0) n = cyc;
      end
      bus.OutWr = 1'b0;
      while (cyc != n + 80) begin
         @(posedge clk);
         #1;
      end
      vectors++;
      if (bus.Full !== 1'b1) begin
         $display("FAIL fullpop_pre: Full=%b expected 1", bus.Full);
         miscompares++;
      end
      // Sampled on the edge that ends the first word's last stop bit.
      d = 16'hA006;
      bus.OutData = d;
      bus.OutWr   = 1'b1;
      exp_q.push_back(d[15:8]);
      exp_q.push_back(d[7:0]);
      @(posedge clk);
      #1;
      bus.OutWr = 1'b0;
      vectors++;
      if (bus.Overflow !== 1'b0 || bus.Full !== 1'b1) begin
         $display("FAIL fullpop_accept: Overflow=%b Full=%b expected 0 1", bus.Overflow, bus.Full);
         miscompares++;
      end
      wait_rx(12, 700, ok);
      vectors++;
      if (!ok) begin
         $display("FAIL fullpop_rx_count: got %0d bytes expected 12", rx_q.size());
         miscompares++;
      end
      for (int i = 0; rx_q.size() > 0 && exp_q.size() > 0; i++) begin
         e = exp_q.pop_front();
         a = rx_q.pop_front();
         f = rx_ok_q.pop_front();
         void'(rx_cyc_q.pop_front());
         vectors++;
         if (a !== e || !f) begin
            $display("FAIL fullpop_byte%0d: got %h framing_ok=%0d expected %h", i, a, f, e);
            miscompares++;
         end
      end
      wait_idle("fullpop");
      vectors++;
      if (bus.Overflow !== 1'b0 || rx_q.size() !== 0) begin
         $display("FAIL fullpop_end: Overflow=%b extra bytes=%0d expected 0 0", bus.Overflow, rx_q.size());
         miscompares++;
      end
   endtask

   initial begin
      bus.OutWr   = 1'b0;
      bus.OutData = '0;
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_reset_mid();
      test_full_pop();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
